// File: rtl/memory_issue_split.sv
// +--------------------------------------------------------------------------+
// | Module   : memory_issue_split                                            |
// | Brief    : Load/store issue stage that drives the data memory port from  |
// |            registers, splitting word-crossing accesses into two beats.   |
// |            Optional MEMORY_ISSUE_MISALIGN_TRAP_EN traps misaligned ones.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module memory_issue_split #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int NUM_BYTES      = DATA_WIDTH / 8,
    parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic                      load,
    input  logic                      store,
    input  logic [ADDRESS_BITS-1:0]   address,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
    output logic                      memory_read,
    output logic                      memory_write,
    output logic [NUM_BYTES-1:0]      memory_byte_en,
    output logic [ADDRESS_BITS-1:0]   memory_address,
    output logic [DATA_WIDTH-1:0]     memory_data,
    output logic                      memory_second,
    output logic                      memory_last,
`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
    output logic                      misaligned_fault,
`endif
    input  logic                      memory_ready
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BEAT0 = 2'd1;
    localparam logic [1:0] c_ST_BEAT1 = 2'd2;

    localparam logic [LOG2_NUM_BYTES:0]   c_LOG2_MAX  = (LOG2_NUM_BYTES + 1)'(LOG2_NUM_BYTES);
    localparam logic [LOG2_NUM_BYTES+1:0] c_NB_SUM    = (LOG2_NUM_BYTES + 2)'(NUM_BYTES);
    localparam logic [ADDRESS_BITS-1:0]   c_WORD_STEP = ADDRESS_BITS'(NUM_BYTES);
    localparam logic [2*NUM_BYTES-1:0]    c_ONE_WIDE  = {{(2*NUM_BYTES-1){1'b0}}, 1'b1};

    logic [1:0]                  r_state;
    logic [ADDRESS_BITS-1:0]     r_addr1;
    logic [NUM_BYTES-1:0]        r_en1;
    logic [DATA_WIDTH-1:0]       r_data1;

    logic                        w_accept;
    logic [LOG2_NUM_BYTES-1:0]   w_off;
    logic [LOG2_NUM_BYTES:0]     w_log2_eff;
    logic [LOG2_NUM_BYTES:0]     w_size;
    logic [LOG2_NUM_BYTES+1:0]   w_sum;
    logic                        w_split;
    logic [2*NUM_BYTES-1:0]      w_mask;
    logic [2*NUM_BYTES-1:0]      w_en_wide;
    logic [2*DATA_WIDTH-1:0]     w_data_wide;
    logic [ADDRESS_BITS-1:0]     w_base;
    logic [ADDRESS_BITS-1:0]     w_next_base;

    assign w_accept    = issue_valid & issue_ready & (load | store);
    assign w_off       = address[LOG2_NUM_BYTES-1:0];
    assign w_log2_eff  = ({1'b0, log2_bytes} > c_LOG2_MAX) ? c_LOG2_MAX : {1'b0, log2_bytes};
    assign w_size      = {{LOG2_NUM_BYTES{1'b0}}, 1'b1} << w_log2_eff;
    assign w_sum       = {2'b00, w_off} + {1'b0, w_size};
    assign w_split     = w_sum > c_NB_SUM;

    // Double-width lanes: the low half is beat 0, the high half spills into beat 1.
    assign w_mask      = (c_ONE_WIDE << w_size) - c_ONE_WIDE;
    assign w_en_wide   = w_mask << w_off;
    assign w_data_wide = {{DATA_WIDTH{1'b0}}, store_data} << {w_off, 3'b000};

    assign w_base      = {address[ADDRESS_BITS-1:LOG2_NUM_BYTES], {LOG2_NUM_BYTES{1'b0}}};
    assign w_next_base = w_base + c_WORD_STEP;

`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ({1'b0, w_off} & (w_size - {{LOG2_NUM_BYTES{1'b0}}, 1'b1})) != '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            issue_ready    <= 1'b1;
            memory_read    <= 1'b0;
            memory_write   <= 1'b0;
            memory_byte_en <= '0;
            memory_address <= '0;
            memory_data    <= '0;
            memory_second  <= 1'b0;
            memory_last    <= 1'b0;
            r_addr1        <= '0;
            r_en1          <= '0;
            r_data1        <= '0;
`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
            misaligned_fault <= 1'b0;
`endif
        end else begin
`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
            misaligned_fault <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            misaligned_fault <= 1'b1;
                        end else
`endif
                        begin
                            r_state        <= c_ST_BEAT0;
                            issue_ready    <= 1'b0;
                            memory_write   <= store;
                            memory_read    <= load & ~store;
                            memory_address <= w_base;
                            memory_byte_en <= w_en_wide[NUM_BYTES-1:0];
                            memory_data    <= store ? w_data_wide[DATA_WIDTH-1:0] : '0;
                            memory_second  <= 1'b0;
                            memory_last    <= ~w_split;
                            r_addr1        <= w_next_base;
                            r_en1          <= w_en_wide[2*NUM_BYTES-1:NUM_BYTES];
                            r_data1        <= store ? w_data_wide[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
                        end
                    end
                end
                c_ST_BEAT0: begin
                    if (memory_ready) begin
                        if (memory_last) begin
                            r_state        <= c_ST_IDLE;
                            issue_ready    <= 1'b1;
                            memory_read    <= 1'b0;
                            memory_write   <= 1'b0;
                            memory_byte_en <= '0;
                            memory_address <= '0;
                            memory_data    <= '0;
                            memory_last    <= 1'b0;
                        end else begin
                            r_state        <= c_ST_BEAT1;
                            memory_address <= r_addr1;
                            memory_byte_en <= r_en1;
                            memory_data    <= r_data1;
                            memory_second  <= 1'b1;
                            memory_last    <= 1'b1;
                        end
                    end
                end
                c_ST_BEAT1: begin
                    if (memory_ready) begin
                        r_state        <= c_ST_IDLE;
                        issue_ready    <= 1'b1;
                        memory_read    <= 1'b0;
                        memory_write   <= 1'b0;
                        memory_byte_en <= '0;
                        memory_address <= '0;
                        memory_data    <= '0;
                        memory_second  <= 1'b0;
                        memory_last    <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    issue_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_issue_split.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_memory_issue_split                                         |
// | Brief    : Scoreboard bench for memory_issue_split (default build).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_memory_issue_split;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  en;
        logic [19:0] addr;
        logic [31:0] data;
        logic        sec;
        logic        last;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [19:0] address = '0;
    logic [31:0] store_data = '0;
    logic [1:0]  log2_bytes = '0;
    logic        memory_read;
    logic        memory_write;
    logic [3:0]  memory_byte_en;
    logic [19:0] memory_address;
    logic [31:0] memory_data;
    logic        memory_second;
    logic        memory_last;
    logic        memory_ready = 1'b0;
`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
    logic        misaligned_fault;
`endif

    int    checks = 0;
    int    failures = 0;
    int    stall_cycles = 0;
    int    wait_cnt = 0;
    beat_t exp_q[$];

    memory_issue_split dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .load           (load),
        .store          (store),
        .address        (address),
        .store_data     (store_data),
        .log2_bytes     (log2_bytes),
        .memory_read    (memory_read),
        .memory_write   (memory_write),
        .memory_byte_en (memory_byte_en),
        .memory_address (memory_address),
        .memory_data    (memory_data),
        .memory_second  (memory_second),
        .memory_last    (memory_last),
`ifdef MEMORY_ISSUE_MISALIGN_TRAP_EN
        .misaligned_fault (misaligned_fault),
`endif
        .memory_ready   (memory_ready)
    );

    always #5 clock = ~clock;

    function automatic beat_t actual_beat();
        beat_t b;
        b = '{memory_read, memory_write, memory_byte_en, memory_address,
              memory_data, memory_second, memory_last};
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_beat(input logic rd, input logic wr, input logic [3:0] en,
                             input logic [19:0] a, input logic [31:0] d,
                             input logic sec, input logic last);
        beat_t b;
        b = '{rd, wr, en, a, d, sec, last};
        exp_q.push_back(b);
    endtask

    // Memory responder: holds memory_ready low stall_cycles cycles per beat.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset && (memory_read || memory_write)) begin
                if (wait_cnt >= stall_cycles) begin
                    memory_ready = 1'b1;
                    wait_cnt = 0;
                end else begin
                    memory_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                memory_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every active cycle must match the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && (memory_read || memory_write)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(actual_beat()), 64'd0);
                end else begin
                    chk("beat", 64'(actual_beat()), 64'(exp_q[0]));
                    if (memory_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic ld, input logic st, input logic [19:0] a,
                        input logic [31:0] d, input logic [1:0] lg);
        int n;
        n = 0;
        while (!issue_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        chk("accept_wait", 64'(issue_ready), 64'd1);
        issue_valid = 1'b1; load = ld; store = st;
        address = a; store_data = d; log2_bytes = lg;
        @(posedge clock); #1;
        issue_valid = 1'b0; load = 1'b0; store = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!issue_ready && n < 200) begin
            @(posedge clock); #1; n++;
        end
        chk("idle_wait", 64'(issue_ready), 64'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ready", 64'(issue_ready), 64'd1);
        chk("reset_outputs", 64'(actual_beat()), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Reset asserted while beat 0 of a split store is stalled.
        stall_cycles = 100;
        push_beat(1'b0, 1'b1, 4'b1100, 20'h00004, 32'hCCDD0000, 1'b0, 1'b0);
        send(1'b0, 1'b1, 20'h00006, 32'hAABBCCDD, 2'd2);
        @(posedge clock); #1;
        chk("midsplit_active", 64'(memory_write), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midsplit_reset_ready", 64'(issue_ready), 64'd1);
        chk("midsplit_reset_outputs", 64'(actual_beat()), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        stall_cycles = 0;
        @(posedge clock); #1;

        // Aligned word store.
        push_beat(1'b0, 1'b1, 4'b1111, 20'h00010, 32'hAABBCCDD, 1'b0, 1'b1);
        send(1'b0, 1'b1, 20'h00010, 32'hAABBCCDD, 2'd2);
        @(posedge clock); #1;
        chk("sw_ready_after", 64'(issue_ready), 64'd1);

        // Split word store.
        push_beat(1'b0, 1'b1, 4'b1100, 20'h00004, 32'hCCDD0000, 1'b0, 1'b0);
        push_beat(1'b0, 1'b1, 4'b0011, 20'h00008, 32'h0000AABB, 1'b1, 1'b1);
        send(1'b0, 1'b1, 20'h00006, 32'hAABBCCDD, 2'd2);
        wait_idle(n);

        // Split halfword store, three stall cycles per beat.
        stall_cycles = 3;
        push_beat(1'b0, 1'b1, 4'b1000, 20'h00000, 32'h34000000, 1'b0, 1'b0);
        push_beat(1'b0, 1'b1, 4'b0001, 20'h00004, 32'h00000012, 1'b1, 1'b1);
        send(1'b0, 1'b1, 20'h00003, 32'h00001234, 2'd1);
        wait_idle(n);
        chk("sh_stall_cycles", 64'(n), 64'd8);
        stall_cycles = 0;

        // Split word load wrapping the address space.
        push_beat(1'b1, 1'b0, 4'b1100, 20'hFFFFC, 32'h0, 1'b0, 1'b0);
        push_beat(1'b1, 1'b0, 4'b0011, 20'h00000, 32'h0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 20'hFFFFE, 32'hDEADBEEF, 2'd2);
        wait_idle(n);

        // Request with neither load nor store is ignored.
        issue_valid = 1'b1; load = 1'b0; store = 1'b0; address = 20'h00040;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("illegal_ready", 64'(issue_ready), 64'd1);
            chk("illegal_no_beat", 64'({memory_read, memory_write}), 64'd0);
        end
        issue_valid = 1'b0;

        // Byte store inside a word.
        push_beat(1'b0, 1'b1, 4'b0010, 20'h00004, 32'h00007F00, 1'b0, 1'b1);
        send(1'b0, 1'b1, 20'h00005, 32'h0000007F, 2'd0);
        wait_idle(n);

        // Load and store together act as a store.
        push_beat(1'b0, 1'b1, 4'b1100, 20'h00020, 32'hBEEF0000, 1'b0, 1'b1);
        send(1'b1, 1'b1, 20'h00022, 32'h0000BEEF, 2'd1);
        wait_idle(n);

        // Oversized log2_bytes behaves as a full word (split at offset 1).
        push_beat(1'b0, 1'b1, 4'b1110, 20'h00030, 32'h33221100, 1'b0, 1'b0);
        push_beat(1'b0, 1'b1, 4'b0001, 20'h00034, 32'h00000044, 1'b1, 1'b1);
        send(1'b0, 1'b1, 20'h00031, 32'h44332211, 2'd3);
        wait_idle(n);

        repeat (2) @(posedge clock);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
